// File: rtl/dpram_scheduler.sv
// dpram_scheduler
//   Round-robin scheduler that maps up to NREQ requesters onto the two ports
//   of an external dual-port RAM. Each cycle the first two valid requesters
//   found from the rotating pointer are granted, one on port A and one on
//   port B. The second grant is withheld if it hits the same address as the
//   first and either access is a write. Read data returns one cycle after
//   the grant.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_we [NREQ]   per-requester request and write flag
//   req_addr  [NREQ*AW]       flattened addresses, requester i at [i*AW +: AW]
//   req_wdata [NREQ*WIDTH]    flattened write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready [NREQ]          combinational grant for the current cycle
//   rsp_valid [NREQ]          read response valid per requester
//   rsp_rdata [WIDTH]         read response data
//   w_en_x/addr_x/data_in_x   RAM port A/B controls
//   data_out_a/b              RAM read data, one cycle after the address
module dpram_scheduler #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  w_en_a,
  output logic                  w_en_b,
  output logic [AW-1:0]         addr_a,
  output logic [AW-1:0]         addr_b,
  output logic [WIDTH-1:0]      data_in_a,
  output logic [WIDTH-1:0]      data_in_b,
  input  logic [WIDTH-1:0]      data_out_a,
  input  logic [WIDTH-1:0]      data_out_b
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // (p + k) mod NREQ, valid for p < NREQ and k <= NREQ
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  logic [AW-1:0]    addr_arr [NREQ];
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_wdata[i*WIDTH +: WIDTH];
  end

  // Arbitration state and registered read bookkeeping
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             rd_a_vld_q, rd_a_vld_d, rd_b_vld_q, rd_b_vld_d;
  logic [IW-1:0]    rd_a_idx_q, rd_a_idx_d, rd_b_idx_q, rd_b_idx_d;
  // Port-B data of a dual read, replayed one cycle after the port-A data
  logic             hold_vld_q, hold_vld_d;
  logic [IW-1:0]    hold_idx_q, hold_idx_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  logic          found_a, found_b, grant_a, grant_b;
  logic [IW-1:0] idx_a, idx_b;

  // Scan from ptr: first valid goes to A, next valid is the B candidate.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[wrap_inc(ptr_q, k)]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = wrap_inc(ptr_q, k);
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = wrap_inc(ptr_q, k);
        end
      end
    end
    grant_a = found_a && !rst;
    // Same address with any write involved would race inside the RAM;
    // the B candidate waits. Two reads to one address are harmless.
    grant_b = found_b && !rst &&
              !((addr_arr[idx_a] == addr_arr[idx_b]) && (req_we[idx_a] || req_we[idx_b]));
  end

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[idx_a] = 1'b1;
    if (grant_b) req_ready[idx_b] = 1'b1;
  end

  assign w_en_a    = grant_a && req_we[idx_a];
  assign addr_a    = grant_a ? addr_arr[idx_a] : '0;
  assign data_in_a = grant_a ? data_arr[idx_a] : '0;
  assign w_en_b    = grant_b && req_we[idx_b];
  assign addr_b    = grant_b ? addr_arr[idx_b] : '0;
  assign data_in_b = grant_b ? data_arr[idx_b] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_b)      ptr_d = wrap_inc(idx_b, 1);
    else if (grant_a) ptr_d = wrap_inc(idx_a, 1);
    rd_a_vld_d  = grant_a && !req_we[idx_a];
    rd_a_idx_d  = idx_a;
    rd_b_vld_d  = grant_b && !req_we[idx_b];
    rd_b_idx_d  = idx_b;
    // data_out_b is only valid this cycle, so capture it for the replay
    hold_vld_d  = rd_a_vld_q && rd_b_vld_q;
    hold_idx_d  = rd_b_idx_q;
    hold_data_d = data_out_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rd_a_vld_q  <= 1'b0;
      rd_a_idx_q  <= '0;
      rd_b_vld_q  <= 1'b0;
      rd_b_idx_q  <= '0;
      hold_vld_q  <= 1'b0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rd_a_vld_q  <= rd_a_vld_d;
      rd_a_idx_q  <= rd_a_idx_d;
      rd_b_vld_q  <= rd_b_vld_d;
      rd_b_idx_q  <= rd_b_idx_d;
      hold_vld_q  <= hold_vld_d;
      hold_idx_q  <= hold_idx_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Responses are masked during reset so a read granted just before reset
  // never surfaces. The replayed port-B word owns rsp_rdata in its cycle;
  // otherwise port A data wins over port B.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!rst) begin
      if (rd_a_vld_q) rsp_valid[rd_a_idx_q] = 1'b1;
      if (rd_b_vld_q) rsp_valid[rd_b_idx_q] = 1'b1;
      if (hold_vld_q) rsp_valid[hold_idx_q] = 1'b1;
      if (hold_vld_q)      rsp_rdata = hold_data_q;
      else if (rd_a_vld_q) rsp_rdata = data_out_a;
      else if (rd_b_vld_q) rsp_rdata = data_out_b;
    end
  end

endmodule

// File: tb/tb_dpram_scheduler.sv
module tb_dpram_scheduler;
  localparam int DEPTH = 8, WIDTH = 8, NREQ = 4, AW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  w_en_a, w_en_b;
  logic [AW-1:0]         addr_a, addr_b;
  logic [WIDTH-1:0]      data_in_a, data_in_b, data_out_a, data_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .w_en_a(w_en_a), .w_en_b(w_en_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b));

  // Behavioural dual-port RAM, synchronous read
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (w_en_a) mem[addr_a] <= data_in_a;
    if (w_en_b) mem[addr_b] <= data_in_b;
    data_out_a <= mem[addr_a];
    data_out_b <= mem[addr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW]        = a;
    req_wdata[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic test_reset();
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    step();
    checks++; if ({w_en_a, w_en_b} !== 2'b00) begin errors++; $display("FAIL reset_wen got %b exp 00", {w_en_a, w_en_b}); end
    checks++; if ({addr_a, addr_b, data_in_a, data_in_b} !== '0) begin errors++; $display("FAIL reset_port got %h exp 0", {addr_a, addr_b, data_in_a, data_in_b}); end
    checks++; if ({rsp_valid, rsp_rdata} !== '0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_rdata}); end
    clr_req(); rst = 1'b0;
    step();
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q); end
    checks++; if ({req_ready, rsp_valid} !== 8'h00) begin errors++; $display("FAIL idle_out got %h exp 00", {req_ready, rsp_valid}); end
  endtask

  task automatic test_dual_write();
    set_req(0, 1'b1, 3'd2, 8'h11);
    set_req(1, 1'b1, 3'd5, 8'h22);
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL dw_ready got %b exp 0011", req_ready); end
    checks++; if ({w_en_a, addr_a, data_in_a} !== {1'b1, 3'd2, 8'h11}) begin errors++; $display("FAIL dw_porta got %h exp %h", {w_en_a, addr_a, data_in_a}, {1'b1, 3'd2, 8'h11}); end
    checks++; if ({w_en_b, addr_b, data_in_b} !== {1'b1, 3'd5, 8'h22}) begin errors++; $display("FAIL dw_portb got %h exp %h", {w_en_b, addr_b, data_in_b}, {1'b1, 3'd5, 8'h22}); end
    step(); clr_req();
    checks++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL dw_ptr got %0d exp 2", dut.ptr_q); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL dw_rsp got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_write_conflict();
    set_req(0, 1'b1, 3'd3, 8'hAA);
    set_req(1, 1'b1, 3'd3, 8'hBB);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wc_ready got %b exp 0001", req_ready); end
    checks++; if ({w_en_a, addr_a, data_in_a} !== {1'b1, 3'd3, 8'hAA}) begin errors++; $display("FAIL wc_porta got %h exp %h", {w_en_a, addr_a, data_in_a}, {1'b1, 3'd3, 8'hAA}); end
    checks++; if ({w_en_b, addr_b, data_in_b} !== '0) begin errors++; $display("FAIL wc_portb_idle got %h exp 0", {w_en_b, addr_b, data_in_b}); end
    step();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL wc_ptr got %0d exp 1", dut.ptr_q); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wc_ready2 got %b exp 0010", req_ready); end
    checks++; if ({w_en_a, addr_a, data_in_a} !== {1'b1, 3'd3, 8'hBB}) begin errors++; $display("FAIL wc_porta2 got %h exp %h", {w_en_a, addr_a, data_in_a}, {1'b1, 3'd3, 8'hBB}); end
    step(); clr_req();
    set_req(2, 1'b0, 3'd3, 8'h00);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wc_rd_ready got %b exp 0100", req_ready); end
    step(); clr_req();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL wc_rd_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_rdata !== 8'hBB) begin errors++; $display("FAIL wc_rd_data got %h exp bb", rsp_rdata); end
    step();
  endtask

  task automatic test_read_latency();
    set_req(2, 1'b0, 3'd5, 8'h00);
    #1;
    checks++; if ({req_ready, rsp_valid} !== 8'b0100_0000) begin errors++; $display("FAIL rl_grant got %b exp 01000000", {req_ready, rsp_valid}); end
    step(); clr_req();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL rl_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h22) begin errors++; $display("FAIL rl_data got %h exp 22", rsp_rdata); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== '0) begin errors++; $display("FAIL rl_after got %h exp 0", {rsp_valid, rsp_rdata}); end
    checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL rl_ptr got %0d exp 3", dut.ptr_q); end
  endtask

  task automatic test_dual_read();
    set_req(3, 1'b0, 3'd2, 8'h00);
    set_req(0, 1'b0, 3'd5, 8'h00);
    #1;
    checks++; if ({req_ready, addr_a, addr_b} !== {4'b1001, 3'd2, 3'd5}) begin errors++; $display("FAIL dr_grant got %h exp %h", {req_ready, addr_a, addr_b}, {4'b1001, 3'd2, 3'd5}); end
    step(); clr_req();
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b1001, 8'h11}) begin errors++; $display("FAIL dr_first got %h exp %h", {rsp_valid, rsp_rdata}, {4'b1001, 8'h11}); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b0001, 8'h22}) begin errors++; $display("FAIL dr_replay got %h exp %h", {rsp_valid, rsp_rdata}, {4'b0001, 8'h22}); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== '0) begin errors++; $display("FAIL dr_after got %h exp 0", {rsp_valid, rsp_rdata}); end
    checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL dr_ptr got %0d exp 1", dut.ptr_q); end
  endtask

  task automatic test_same_addr();
    set_req(1, 1'b0, 3'd5, 8'h00);
    set_req(2, 1'b1, 3'd5, 8'h22);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sa_rw_ready got %b exp 0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    #1;
    checks++; if ({req_ready, w_en_a} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL sa_w_grant got %b exp 01001", {req_ready, w_en_a}); end
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b0010, 8'h22}) begin errors++; $display("FAIL sa_r_rsp got %h exp %h", {rsp_valid, rsp_rdata}, {4'b0010, 8'h22}); end
    step(); clr_req();
    set_req(1, 1'b0, 3'd5, 8'h00);
    set_req(2, 1'b0, 3'd5, 8'h00);
    #1;
    checks++; if ({req_ready, addr_a, addr_b} !== {4'b0110, 3'd5, 3'd5}) begin errors++; $display("FAIL sa_rr_grant got %h exp %h", {req_ready, addr_a, addr_b}, {4'b0110, 3'd5, 3'd5}); end
    step(); clr_req();
    checks++; if ({rsp_valid, rsp_rdata} !== {4'b0110, 8'h22}) begin errors++; $display("FAIL sa_rr_rsp got %h exp %h", {rsp_valid, rsp_rdata}, {4'b0110, 8'h22}); end
    step();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL sa_rr_replay got %b exp 0100", rsp_valid); end
    checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL sa_ptr got %0d exp 3", dut.ptr_q); end
    step();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy [4];
    exp_rdy[0] = 4'b0011; exp_rdy[1] = 4'b1100; exp_rdy[2] = 4'b0011; exp_rdy[3] = 4'b1100;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL fair_c%0d got %b exp %b", c, req_ready, exp_rdy[c]); end
      if (c == 2) begin
        // fresh reads of 2,3 plus replay of 1
        checks++; if (rsp_valid !== 4'b1110) begin errors++; $display("FAIL fair_rsp got %b exp 1110", rsp_valid); end
      end
      step();
    end
    clr_req();
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL fair_ptr got %0d exp 0", dut.ptr_q); end
    step(); step();
  endtask

  task automatic test_reset_mid_read();
    set_req(0, 1'b0, 3'd2, 8'h00);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_grant got %b exp 0001", req_ready); end
    step(); clr_req(); rst = 1'b1;
    #1;
    checks++; if ({rsp_valid, rsp_rdata} !== '0) begin errors++; $display("FAIL rm_in_rst got %h exp 0", {rsp_valid, rsp_rdata}); end
    step(); rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_after got %b exp 0000", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_after2 got %b exp 0000", rsp_valid); end
  endtask

  initial begin
    rst = 1'b1;
    clr_req();
    test_reset();
    test_dual_write();
    test_write_conflict();
    test_read_latency();
    test_dual_read();
    test_same_addr();
    test_fairness();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_scheduler.md
DPRAM_SCHEDULER -- requirements
Module: dpram_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of RAM words.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per word.
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-004 SHALL define AW = $clog2(DEPTH) as the address width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  NREQ  per-requester access request.
REQ-009 req_we  input  NREQ  per-requester write (1) or read (0).
REQ-010 req_addr  input  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
REQ-011 req_wdata  input  NREQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-012 req_ready  output  NREQ  per-requester grant for the current cycle.
REQ-013 rsp_valid  output  NREQ  read data valid for requester i.
REQ-014 rsp_rdata  output  WIDTH  read data for the requester whose rsp_valid is high.
REQ-015 w_en_a, w_en_b  output  1 each  RAM port write enables.
REQ-016 addr_a, addr_b  output  AW each  RAM port addresses.
REQ-017 data_in_a, data_in_b  output  WIDTH each  RAM port write data.
REQ-018 data_out_a, data_out_b  input  WIDTH each  RAM read data, valid the cycle after the address is applied.

Function
REQ-019 SHALL hold a round-robin pointer ptr (0..NREQ-1) as its only arbitration state.
REQ-020 SHALL scan requesters in the order ptr, ptr+1, ..., wrapping modulo NREQ, considering only those with req_valid high.
REQ-021 SHALL grant the first valid requester found onto port A and the second onto port B, in the same cycle.
REQ-022 SHALL NOT grant the second requester if its address equals the first requester's address and either access is a write; that requester stays pending.
REQ-023 SHALL grant two reads to the same address on both ports.
REQ-024 SHALL assert req_ready[i] combinationally in the cycle requester i is granted; a transfer completes when req_valid[i] and req_ready[i] are both high at the clock edge.
REQ-025 SHALL drive each granted port with that requester's address, write data and write enable.
REQ-026 SHALL drive an ungranted port with w_en=0, addr=0 and data_in=0.
REQ-027 SHALL update ptr after a cycle with one or more grants to (last granted index + 1) mod NREQ.
REQ-028 SHALL leave ptr unchanged in a cycle with no grants.
REQ-029 SHALL register, for each granted read, the requester index and port used.
REQ-030 SHALL assert rsp_valid[i] exactly one cycle after requester i's read grant, for one cycle.
REQ-031 SHALL drive rsp_rdata from data_out of the registered port for that requester.
REQ-032 SHALL, when both ports served reads in the previous cycle, assert both rsp_valid bits together and present the port-A requester's data on rsp_rdata.
REQ-033 SHALL additionally provide per-port data through rsp_valid ordering: the port-B requester's data is re-presented on rsp_rdata in the next cycle, and its rsp_valid is held until then.
REQ-034 SHALL keep rsp_valid at 0 for writes.
REQ-035 SHALL drive rsp_rdata to 0 when no rsp_valid bit is high.
REQ-036 SHALL allow a requester to be regranted while its own earlier response is still being returned.

Reset
REQ-037 SHALL, while rst is high, drive ptr=0, all rsp_valid=0, rsp_rdata=0, all req_ready=0, w_en_a=w_en_b=0, addr and data_in outputs 0, and clear the registered response state.
REQ-038 SHALL drop any read granted in the cycle before rst is asserted mid-operation; no rsp_valid follows.
REQ-039 SHALL accept requests normally in the first cycle after rst deasserts.

Verification
REQ-040 Reset then idle: rst=1 for 2 cycles -> all outputs 0; ptr=0 after release.
REQ-041 Dual write: req0 writes 0x11 to addr 2, req1 writes 0x22 to addr 5 in the same cycle -> port A addr 2 w_en 1, port B addr 5 w_en 1, req_ready=0011, ptr=2.
REQ-042 Write conflict: req0 and req1 both write addr 3 -> only req0 is granted; req1 is granted on port A the next cycle with ptr=1, and a later read of addr 3 returns req1's data.
REQ-043 Read latency: req2 reads addr 5 after it holds 0x22 -> rsp_valid=0100 one cycle after the grant, rsp_rdata=0x22.
REQ-044 Fairness: all four requesters are held valid as reads for 4 cycles -> grant pairs are {0,1}, {2,3}, {0,1}, {2,3} and no requester starves.
REQ-045 Reset mid-read: rst is asserted the cycle after req0's read grant -> rsp_valid stays 0000.
